demux_1_2_stream: RTL and testbench

DEMUX_1_2_STREAM -- requirements
Module: demux_1_2_stream

---
 rtl/demux_1_2_stream_pkg.sv | 18 +
 rtl/demux_out_slot.sv | 53 +++++
 rtl/demux_1_2_stream.sv | 78 +++++++
 tb/tb_demux_1_2_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1_2_stream_pkg.sv
// Shared defaults, port indices and the destination-select helper
// for the 1:2 stream demultiplexer.
package demux_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int NUM_PORTS = 2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Destination of the offered word: the toggle bit in alternate
    // mode, otherwise the explicit select.
    function automatic logic route(input logic alt_en, input logic toggle, input logic sel);
        return alt_en ? toggle : sel;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Single registered output slot with valid/ready handshake and a
// delivered-word counter.
module demux_out_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             space,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             deliver;

    assign deliver = valid_reg & ready;
    // A word can be taken when the slot is empty or empties this cycle.
    assign space   = ~valid_reg | ready;

    // Slot register: a load wins over a delivery so a refill keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
        end else if (deliver) begin
            valid_reg <= 1'b0;
        end
    end

    // Count every delivered word, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (deliver) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;
    assign cnt   = cnt_reg;

endmodule

// File: rtl/demux_1_2_stream.sv
// 1:2 stream demultiplexer: routes each accepted word to one of two
// registered output slots, chosen by in_sel or by an internal toggle.
module demux_1_2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alt_en,
    output logic [WIDTH-1:0] y0_data,
    output logic [WIDTH-1:0] y1_data,
    output logic             y0_valid,
    output logic             y1_valid,
    input  logic             y0_ready,
    input  logic             y1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic                 toggle_reg;
    logic                 dest;
    logic                 accept;
    logic [WIDTH-1:0]     slot_data [NUM_PORTS];
    logic [CNT_W-1:0]     slot_cnt  [NUM_PORTS];
    logic [NUM_PORTS-1:0] slot_valid;
    logic [NUM_PORTS-1:0] slot_space;
    logic [NUM_PORTS-1:0] slot_ready;
    logic [NUM_PORTS-1:0] slot_load;

    assign dest       = route(alt_en, toggle_reg, in_sel);
    assign in_ready   = slot_space[dest];
    assign accept     = in_valid & in_ready;
    assign slot_ready = {y1_ready, y0_ready};

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
            assign slot_load[gi] = accept & (dest == 1'(gi));

            demux_out_slot #(
                .WIDTH(WIDTH),
                .CNT_W(CNT_W)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .load     (slot_load[gi]),
                .load_data(in_data),
                .data     (slot_data[gi]),
                .valid    (slot_valid[gi]),
                .ready    (slot_ready[gi]),
                .space    (slot_space[gi]),
                .cnt      (slot_cnt[gi])
            );
        end
    endgenerate

    // Toggle flips on each accepted word in alternate mode and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_reg <= 1'b0;
        end else if (accept && alt_en) begin
            toggle_reg <= ~toggle_reg;
        end
    end

    assign y0_data  = slot_data[PORT0];
    assign y1_data  = slot_data[PORT1];
    assign y0_valid = slot_valid[PORT0];
    assign y1_valid = slot_valid[PORT1];
    assign cnt0     = slot_cnt[PORT0];
    assign cnt1     = slot_cnt[PORT1];

endmodule

// File: tb/tb_demux_1_2_stream.sv
// Directed testbench for demux_1_2_stream.
`timescale 1ns/1ps
module tb_demux_1_2_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       alt_en = 1'b0;
    logic [7:0] y0_data, y1_data;
    logic       y0_valid, y1_valid;
    logic       y0_ready = 1'b0;
    logic       y1_ready = 1'b0;
    logic [7:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_1_2_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_sel  (in_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alt_en  (alt_en),
        .y0_data (y0_data),
        .y1_data (y1_data),
        .y0_valid(y0_valid),
        .y1_valid(y1_valid),
        .y0_ready(y0_ready),
        .y1_ready(y1_ready),
        .cnt0    (cnt0),
        .cnt1    (cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; alt_en = 1'b0;
        y0_ready = 1'b0; y1_ready = 1'b0; in_data = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y0_valid got=%b exp=0", y0_valid); end
        n_checks++; if (y1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y1_valid got=%b exp=0", y1_valid); end
        n_checks++; if (y0_data !== 8'h00) begin n_fail++; $display("FAIL reset_y0_data got=%h exp=00", y0_data); end
        n_checks++; if (y1_data !== 8'h00) begin n_fail++; $display("FAIL reset_y1_data got=%h exp=00", y1_data); end
        n_checks++; if (cnt0 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
        n_checks++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
        // first transfer right after release
        step();
        rst = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h33;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b1 || y0_data !== 8'h33) begin n_fail++; $display("FAIL first_xfer valid=%b data=%h exp 1/33", y0_valid, y0_data); end
        $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_basic();
        do_reset();
        y0_ready = 1'b1; y1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready0 got=%b exp=1", in_ready); end
        step();
        in_sel = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b1 || y0_data !== 8'h11) begin n_fail++; $display("FAIL basic_y0 valid=%b data=%h exp 1/11", y0_valid, y0_data); end
        n_checks++; if (y1_valid !== 1'b0) begin n_fail++; $display("FAIL basic_y1_idle got=%b exp=0", y1_valid); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (y1_valid !== 1'b1 || y1_data !== 8'hA5) begin n_fail++; $display("FAIL basic_y1 valid=%b data=%h exp 1/a5", y1_valid, y1_data); end
        n_checks++; if (y0_valid !== 1'b0 || cnt0 !== 8'd1) begin n_fail++; $display("FAIL basic_y0_done valid=%b cnt0=%0d exp 0/1", y0_valid, cnt0); end
        step();
        @(negedge clk);
        n_checks++; if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin n_fail++; $display("FAIL basic_counts cnt0=%0d cnt1=%0d exp 1/1", cnt0, cnt1); end
        $display("test_basic done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_stall();
        do_reset();
        y0_ready = 1'b0; y1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h01;
        step();
        in_sel = 1'b1; in_data = 8'h77;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_port1_ready got=%b exp=1", in_ready); end
        step();
        in_sel = 1'b0; in_data = 8'h02;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (y1_valid !== 1'b1 || y1_data !== 8'h77) begin n_fail++; $display("FAIL stall_y1 valid=%b data=%h exp 1/77", y1_valid, y1_data); end
        step();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || y0_valid !== 1'b1 || y0_data !== 8'h01) begin n_fail++; $display("FAIL stall_hold ready=%b valid=%b data=%h exp 0/1/01", in_ready, y0_valid, y0_data); end
        n_checks++; if (y1_valid !== 1'b0 || cnt1 !== 8'd1 || cnt0 !== 8'd0) begin n_fail++; $display("FAIL stall_counts y1v=%b cnt0=%0d cnt1=%0d exp 0/0/1", y1_valid, cnt0, cnt1); end
        step();
        y0_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL refill_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b1 || y0_data !== 8'h02 || cnt0 !== 8'd1) begin n_fail++; $display("FAIL refill_no_bubble valid=%b data=%h cnt0=%0d exp 1/02/1", y0_valid, y0_data, cnt0); end
        step();
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b0 || cnt0 !== 8'd2) begin n_fail++; $display("FAIL stall_drain valid=%b cnt0=%0d exp 0/2", y0_valid, cnt0); end
        $display("test_stall done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_alt();
        logic [7:0] exp_d;
        do_reset();
        y0_ready = 1'b1; y1_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            in_valid = 1'b1; alt_en = 1'b1; in_sel = 1'b1; in_data = 8'h10 + 8'(i);
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alt_ready_%0d got=%b exp=1", i, in_ready); end
            if (i > 0) begin
                exp_d = 8'h10 + 8'(i - 1);
                if (((i - 1) % 2) == 0) begin
                    n_checks++; if (y0_valid !== 1'b1 || y0_data !== exp_d || y1_valid !== 1'b0) begin n_fail++; $display("FAIL alt_word_%0d y0v=%b y0=%h y1v=%b exp 1/%h/0", i - 1, y0_valid, y0_data, y1_valid, exp_d); end
                end else begin
                    n_checks++; if (y1_valid !== 1'b1 || y1_data !== exp_d || y0_valid !== 1'b0) begin n_fail++; $display("FAIL alt_word_%0d y1v=%b y1=%h y0v=%b exp 1/%h/0", i - 1, y1_valid, y1_data, y0_valid, exp_d); end
                end
            end
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b1 || y0_data !== 8'h16 || y1_valid !== 1'b0) begin n_fail++; $display("FAIL alt_toggle_end y0v=%b y0=%h y1v=%b exp 1/16/0", y0_valid, y0_data, y1_valid); end
        step();
        @(negedge clk);
        n_checks++; if (cnt0 !== 8'd4 || cnt1 !== 8'd3) begin n_fail++; $display("FAIL alt_counts cnt0=%0d cnt1=%0d exp 4/3", cnt0, cnt1); end
        // toggle is now 1; switch to explicit select, then back
        step();
        alt_en = 1'b0; in_sel = 1'b0; in_valid = 1'b1; in_data = 8'h20;
        step();
        alt_en = 1'b1; in_sel = 1'b0; in_data = 8'h21;
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b1 || y0_data !== 8'h20 || y1_valid !== 1'b0) begin n_fail++; $display("FAIL alt_off y0v=%b y0=%h y1v=%b exp 1/20/0", y0_valid, y0_data, y1_valid); end
        step();
        in_valid = 1'b0; alt_en = 1'b0;
        @(negedge clk);
        n_checks++; if (y1_valid !== 1'b1 || y1_data !== 8'h21 || y0_valid !== 1'b0) begin n_fail++; $display("FAIL alt_retained y1v=%b y1=%h y0v=%b exp 1/21/0", y1_valid, y1_data, y0_valid); end
        $display("test_alt done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_reset_mid();
        do_reset();
        y0_ready = 1'b1; y1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            in_valid = 1'b1; in_sel = 1'b0; alt_en = (i == 0); in_data = 8'(i);
        end
        step();
        in_valid = 1'b0; alt_en = 1'b0;
        step();
        @(negedge clk);
        n_checks++; if (cnt0 !== 8'd5) begin n_fail++; $display("FAIL mid_cnt0_pre got=%0d exp=5", cnt0); end
        step();
        y0_ready = 1'b0; y1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hAA;
        step();
        in_sel = 1'b1; in_data = 8'hBB;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b1 || y0_data !== 8'hAA || y1_valid !== 1'b1 || y1_data !== 8'hBB) begin n_fail++; $display("FAIL mid_full y0v=%b y0=%h y1v=%b y1=%h exp 1/aa/1/bb", y0_valid, y0_data, y1_valid, y1_data); end
        rst = 1'b1;
        #1;
        n_checks++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid y0v=%b y1v=%b exp 0/0", y0_valid, y1_valid); end
        n_checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0 || y0_data !== 8'h00) begin n_fail++; $display("FAIL mid_async_clear cnt0=%0d cnt1=%0d y0=%h exp 0/0/00", cnt0, cnt1, y0_data); end
        step();
        step();
        rst = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
        step();
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0 || cnt0 !== 8'd0) begin n_fail++; $display("FAIL mid_no_stale y0v=%b y1v=%b cnt0=%0d exp 0/0/0", y0_valid, y1_valid, cnt0); end
        step();
        in_valid = 1'b1; alt_en = 1'b1; in_sel = 1'b1; in_data = 8'hCC;
        step();
        in_valid = 1'b0; alt_en = 1'b0;
        @(negedge clk);
        n_checks++; if (y0_valid !== 1'b1 || y0_data !== 8'hCC || y1_valid !== 1'b0) begin n_fail++; $display("FAIL mid_toggle_cleared y0v=%b y0=%h y1v=%b exp 1/cc/0", y0_valid, y0_data, y1_valid); end
        $display("test_reset_mid done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_wrap();
        int stalls;
        stalls = 0;
        do_reset();
        y1_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            if (i > 0) step();
            in_valid = 1'b1; in_sel = 1'b1; in_data = 8'(i);
            @(negedge clk);
            if (in_ready !== 1'b1) stalls++;
        end
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL wrap_stalls got=%0d exp=0", stalls); end
        n_checks++; if (cnt1 !== 8'd1 || cnt0 !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt1 cnt1=%0d cnt0=%0d exp 1/0", cnt1, cnt0); end
        $display("test_wrap done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_alt();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
